pkt_buf_responder: RTL and testbench
====================================

// Module: pkt_buf_responder
// PURPOSE
//  Avalon-MM burst responder (slave) backed by on-chip word RAM. It is the far end of the
//  rd_ctrl/wr_ctrl host ports: it serves burst reads of packet words and absorbs burst writes.
//  Used as a packet source/sink in capture-path simulation and as an on-chip packet buffer.
//  It also keeps sticky error and beat-count status for the driver.
// PARAMETERS
//  DATA_W     32    data width in bits; word = DATA_W/8 bytes
//  DEPTH      1024  RAM depth in words; power of two
//  MAX_BURST  256   largest legal burstcount
// PORTS
//  clk                 in   1       clock
//  reset               in   1       synchronous, active-high reset
//  avs_address         in   32      byte address; bits [1:0] ignored
//  avs_read            in   1       read command
//  avs_write           in   1       write command / write beat
//  avs_writedata       in   DATA_W  write beat data
//  avs_burstcount      in   16      beats in burst; sampled on command accept only
//  avs_waitrequest     out  1       high = command not accepted this cycle
//  avs_readdata        out  DATA_W  read beat data
//  avs_readdatavalid   out  1       avs_readdata valid this cycle
//  err_clr             in   1       clears err
//  busy                out  1       state != IDLE
//  err                 out  1       sticky protocol/range error
//  rd_beats            out  32      read beats returned, wraps at 2^32
//  wr_beats            out  32      write beats stored, wraps at 2^32
// BEHAVIOUR
//  Reset values: state=IDLE, avs_readdata=0, avs_readdatavalid=0, err=0, rd_beats=0, wr_beats=0,
//   burst counters=0. RAM contents are not cleared. Reset mid-burst aborts the burst.
//   readdatavalid is 0 from the cycle after reset; no further beats from the aborted burst.
//  avs_waitrequest = (state==RD_BURST), combinational; 0 in IDLE and WR_BURST.
//  Word index = avs_address[31:2] mod DEPTH; it increments per beat and wraps at DEPTH.
//   err is set if the start word + burstcount - 1 >= DEPTH. The burst is still serviced, wrapping.
//  FSM:
//   IDLE: write accepted (avs_write & !waitrequest) -> writes beat 0.
//    burstcount==1 stays IDLE; otherwise goes to WR_BURST with remaining=burstcount-1.
//   IDLE: read accepted -> RD_BURST with remaining=burstcount and addr latched.
//   IDLE, read & write together: the write is taken, the read is dropped, err is set.
//   IDLE, burstcount==0 or >MAX_BURST: the command is consumed, err is set, no RAM access,
//    no readdatavalid, state stays IDLE.
//   WR_BURST: each cycle with avs_write=1 stores one beat and decrements remaining.
//    Gaps (avs_write=0) are allowed. The last beat returns to IDLE.
//    avs_read=1 in WR_BURST: ignored, err is set.
//   RD_BURST: one RAM address is issued per cycle, with no stalls.
//    After the last address is issued, the next state is IDLE.
//  Read latency: command accepted at cycle T -> beat k (0-based) has readdatavalid at T+2+k.
//   Last beat at T+1+N. waitrequest is high T+1..T+N, so a new command is acceptable at T+N+1.
//  RAM is a registered-read, single-port-per-direction RAM. A write at cycle t is visible to a
//   read address issued at t+1 or later.
//  rd_beats increments per readdatavalid; wr_beats increments per stored write beat.
//  err_clr and a new error in the same cycle: err stays 1 (set wins).
// TESTING
//  1. Reset, write burst addr 0x0, bc=4, data 0xA0..0xA3 -> wr_beats=4, busy low after 4th beat, err=0.
//  2. Read burst addr 0x0, bc=4, accepted T -> readdatavalid T+2..T+5, data 0xA0..0xA3,
//     waitrequest high T+1..T+4.
//  3. Write bc=3 at word DEPTH-1 with 1-cycle gaps -> data at words DEPTH-1, 0, 1; err=1;
//     err_clr -> err=0.
//  4. Read bc=0, then bc=MAX_BURST+1 -> no readdatavalid, err=1, state IDLE.
//  5. read&write together in IDLE, bc=1 -> write stored, no read data, err=1.
//  6. Read bc=8, reset asserted at beat 3 -> readdatavalid=0 from the next cycle, state IDLE,
//     waitrequest=0, RAM data intact on a re-read.

Source files
------------

// File: rtl/pkt_buf_responder.sv
// Avalon-MM burst responder backed by a word RAM: serves burst reads, absorbs burst writes,
// and keeps sticky error plus read/write beat counters for the driver.
module pkt_buf_responder #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned MAX_BURST = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [15:0]       avs_burstcount,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              err_clr,
  output logic              busy,
  output logic              err,
  output logic [31:0]       rd_beats,
  output logic [31:0]       wr_beats
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_e;

  state_e            state_q;
  logic [AW-1:0]     addr_q;
  logic [15:0]       remain_q;
  logic              rvalid_q;
  logic              err_q;
  logic [31:0]       rd_beats_q;
  logic [31:0]       wr_beats_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  logic [AW-1:0]     start_idx;
  logic [31:0]       end_idx;
  logic              idle, bc_bad, range_bad, cmd;
  logic              wr_start, rd_start, wr_beat, rd_issue;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic              err_set_d, err_d;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{avs_address[31:AW+2], avs_address[1:0]};

  always_comb begin
    start_idx = avs_address[AW+1:2];
    end_idx   = 32'(start_idx) + 32'(avs_burstcount) - 32'd1;
    idle      = (state_q == IDLE);
    bc_bad    = (avs_burstcount == '0) || (32'(avs_burstcount) > MAX_BURST);
    range_bad = (end_idx >= DEPTH);
    cmd       = idle && (avs_read || avs_write);
    // A simultaneous read is dropped in favour of the write.
    wr_start  = idle && avs_write && !bc_bad;
    rd_start  = idle && avs_read && !avs_write && !bc_bad;
    wr_beat   = (state_q == WR_BURST) && avs_write;
    rd_issue  = (state_q == RD_BURST);
    ram_we    = !reset && (wr_start || wr_beat);
    ram_waddr = idle ? start_idx : addr_q;
    err_set_d = (cmd && (bc_bad || range_bad || (avs_read && avs_write))) ||
                ((state_q == WR_BURST) && avs_read);
    err_d     = err_set_d || (err_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= avs_writedata;
    if (rd_issue) ram_rd_q <= mem[addr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_beats_q <= '0;
      wr_beats_q <= '0;
    end else begin
      rvalid_q <= rd_issue;
      err_q    <= err_d;
      if (rvalid_q) rd_beats_q <= rd_beats_q + 32'd1;
      if (ram_we)   wr_beats_q <= wr_beats_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (wr_start) begin
            if (avs_burstcount != 16'd1) begin
              state_q  <= WR_BURST;
              addr_q   <= start_idx + AW'(1);
              remain_q <= avs_burstcount - 16'd1;
            end
          end else if (rd_start) begin
            state_q  <= RD_BURST;
            addr_q   <= start_idx;
            remain_q <= avs_burstcount;
          end
        end
        WR_BURST: begin
          if (avs_write) begin
            addr_q   <= addr_q + AW'(1);
            remain_q <= remain_q - 16'd1;
            if (remain_q == 16'd1) state_q <= IDLE;
          end
        end
        RD_BURST: begin
          addr_q   <= addr_q + AW'(1);
          remain_q <= remain_q - 16'd1;
          if (remain_q == 16'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avs_waitrequest   = (state_q == RD_BURST);
  assign avs_readdatavalid = rvalid_q;
  // RAM output register carries no reset; gating keeps readdata at zero outside valid beats.
  assign avs_readdata      = rvalid_q ? ram_rd_q : '0;
  assign busy              = (state_q != IDLE);
  assign err               = err_q;
  assign rd_beats          = rd_beats_q;
  assign wr_beats          = wr_beats_q;
endmodule

// File: tb/tb_pkt_buf_responder.sv
// Directed bench for pkt_buf_responder: burst write/read timing, wrap, bad bursts,
// read/write collision and reset during a read burst.
module tb_pkt_buf_responder;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned MAX_BURST = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [15:0] avs_burstcount;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        err_clr;
  logic        busy;
  logic        err;
  logic [31:0] rd_beats;
  logic [31:0] wr_beats;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] rd_buf [16];
  int          rd_cnt;

  pkt_buf_responder #(.DATA_W(32), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_burstcount(avs_burstcount),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .err_clr(err_clr), .busy(busy), .err(err),
    .rd_beats(rd_beats), .wr_beats(wr_beats)
  );

  always #5 clk = ~clk;

  // Issues one read burst and collects returned beats within a bounded window.
  task automatic do_read(input logic [31:0] addr, input logic [15:0] bc);
    @(negedge clk);
    avs_address = addr; avs_burstcount = bc; avs_read = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < int'(bc) + 6; i++) begin
      @(negedge clk);
      avs_read = 1'b0;
      if (avs_readdatavalid) begin
        if (rd_cnt < 16) rd_buf[rd_cnt] = avs_readdata;
        rd_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; avs_read = 1'b0; avs_write = 1'b0; err_clr = 1'b0;
    avs_address = '0; avs_writedata = '0; avs_burstcount = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rst_wait got %b exp 0", avs_waitrequest); end
    n_cmp++; if (avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b exp 0", avs_readdatavalid); end
    n_cmp++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", avs_readdata); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
    n_cmp++; if (rd_beats !== 32'd0) begin n_fail++; $display("FAIL rst_rd_beats got %0d exp 0", rd_beats); end
    n_cmp++; if (wr_beats !== 32'd0) begin n_fail++; $display("FAIL rst_wr_beats got %0d exp 0", wr_beats); end
  endtask

  task automatic test_write_burst();
    @(negedge clk);
    avs_address = 32'h0; avs_burstcount = 16'd4; avs_write = 1'b1; avs_writedata = 32'hA0;
    n_cmp++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL wr_wait got %b exp 0", avs_waitrequest); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy beat %0d got %b exp 1", i, busy); end
      avs_writedata = 32'hA0 + 32'(i);
      avs_burstcount = 16'd0;
    end
    @(negedge clk);
    avs_write = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_done_busy got %b exp 0", busy); end
    n_cmp++; if (wr_beats !== 32'd4) begin n_fail++; $display("FAIL wr_beats got %0d exp 4", wr_beats); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b exp 0", err); end
  endtask

  task automatic test_read_burst();
    logic exp_wait, exp_v;
    @(negedge clk);
    avs_address = 32'h0; avs_burstcount = 16'd4; avs_read = 1'b1;
    n_cmp++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rd_accept_wait got %b exp 0", avs_waitrequest); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      avs_read = 1'b0;
      exp_wait = (k <= 4);
      exp_v    = (k >= 2) && (k <= 5);
      n_cmp++; if (avs_waitrequest !== exp_wait) begin n_fail++; $display("FAIL rd_wait T+%0d got %b exp %b", k, avs_waitrequest, exp_wait); end
      n_cmp++; if (avs_readdatavalid !== exp_v) begin n_fail++; $display("FAIL rd_valid T+%0d got %b exp %b", k, avs_readdatavalid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (avs_readdata !== 32'hA0 + 32'(k - 2)) begin n_fail++; $display("FAIL rd_data T+%0d got %h exp %h", k, avs_readdata, 32'hA0 + 32'(k - 2)); end
      end
    end
    n_cmp++; if (rd_beats !== 32'd4) begin n_fail++; $display("FAIL rd_beats got %0d exp 4", rd_beats); end
  endtask

  task automatic test_wrap_write();
    @(negedge clk);
    avs_address = 32'((DEPTH - 1) * 4); avs_burstcount = 16'd3; avs_write = 1'b1; avs_writedata = 32'hC0;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy cyc %0d got %b exp 1", i, busy); end
      avs_write     = (i % 2 == 0);
      avs_writedata = 32'hC0 + 32'(i / 2);
    end
    @(negedge clk);
    avs_write = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_done_busy got %b exp 0", busy); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL wrap_err got %b exp 1", err); end
    n_cmp++; if (wr_beats !== 32'd7) begin n_fail++; $display("FAIL wrap_wr_beats got %0d exp 7", wr_beats); end
    do_read(32'((DEPTH - 1) * 4), 16'd1);
    n_cmp++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL wrap_rd_cnt_top got %0d exp 1", rd_cnt); end
    n_cmp++; if (rd_buf[0] !== 32'hC0) begin n_fail++; $display("FAIL wrap_word_top got %h exp c0", rd_buf[0]); end
    do_read(32'h0, 16'd2);
    n_cmp++; if (rd_cnt !== 2) begin n_fail++; $display("FAIL wrap_rd_cnt_low got %0d exp 2", rd_cnt); end
    n_cmp++; if (rd_buf[0] !== 32'hC1) begin n_fail++; $display("FAIL wrap_word0 got %h exp c1", rd_buf[0]); end
    n_cmp++; if (rd_buf[1] !== 32'hC2) begin n_fail++; $display("FAIL wrap_word1 got %h exp c2", rd_buf[1]); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL wrap_err_sticky got %b exp 1", err); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL wrap_err_clr got %b exp 0", err); end
  endtask

  task automatic test_bad_burstcount();
    logic [15:0] bcs [2];
    logic seen_v, seen_busy;
    bcs[0] = 16'd0; bcs[1] = 16'(MAX_BURST + 1);
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      avs_address = 32'h10; avs_burstcount = bcs[t]; avs_read = 1'b1;
      seen_v = 1'b0; seen_busy = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        avs_read = 1'b0;
        if (avs_readdatavalid) seen_v = 1'b1;
        if (busy || avs_waitrequest) seen_busy = 1'b1;
      end
      n_cmp++; if (seen_v !== 1'b0) begin n_fail++; $display("FAIL badbc%0d_rvalid got %b exp 0", bcs[t], seen_v); end
      n_cmp++; if (seen_busy !== 1'b0) begin n_fail++; $display("FAIL badbc%0d_busy got %b exp 0", bcs[t], seen_busy); end
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL badbc%0d_err got %b exp 1", bcs[t], err); end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
    end
    n_cmp++; if (rd_beats !== 32'd7) begin n_fail++; $display("FAIL badbc_rd_beats got %0d exp 7", rd_beats); end
  endtask

  task automatic test_rw_collision();
    logic seen_v;
    @(negedge clk);
    avs_address = 32'h40; avs_burstcount = 16'd1; avs_read = 1'b1; avs_write = 1'b1;
    avs_writedata = 32'h55; err_clr = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0; err_clr = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy got %b exp 0", busy); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rw_err_set_wins got %b exp 1", err); end
    seen_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (avs_readdatavalid) seen_v = 1'b1;
    end
    n_cmp++; if (seen_v !== 1'b0) begin n_fail++; $display("FAIL rw_rvalid got %b exp 0", seen_v); end
    n_cmp++; if (wr_beats !== 32'd8) begin n_fail++; $display("FAIL rw_wr_beats got %0d exp 8", wr_beats); end
    do_read(32'h40, 16'd1);
    n_cmp++; if (rd_buf[0] !== 32'h55 || rd_cnt !== 1) begin n_fail++; $display("FAIL rw_stored got %h cnt %0d exp 55 cnt 1", rd_buf[0], rd_cnt); end
    n_cmp++; if (rd_beats !== 32'd8) begin n_fail++; $display("FAIL rw_rd_beats got %0d exp 8", rd_beats); end
  endtask

  task automatic test_reset_mid_burst();
    logic seen_v;
    @(negedge clk);
    avs_address = 32'h80; avs_burstcount = 16'd8; avs_write = 1'b1; avs_writedata = 32'h60;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      avs_writedata = 32'h60 + 32'(i);
    end
    @(negedge clk);
    avs_write = 1'b0;
    @(negedge clk);
    avs_address = 32'h80; avs_burstcount = 16'd8; avs_read = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      avs_read = 1'b0;
      if (k >= 2) begin
        n_cmp++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h60 + 32'(k - 2)) begin
          n_fail++; $display("FAIL mid_beat%0d got v=%b %h exp v=1 %h", k - 2, avs_readdatavalid, avs_readdata, 32'h60 + 32'(k - 2));
        end
      end
      if (k == 5) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid got %b exp 0", avs_readdatavalid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
    n_cmp++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL mid_wait got %b exp 0", avs_waitrequest); end
    n_cmp++; if (rd_beats !== 32'd0 || wr_beats !== 32'd0) begin n_fail++; $display("FAIL mid_counters got %0d/%0d exp 0/0", rd_beats, wr_beats); end
    seen_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (avs_readdatavalid) seen_v = 1'b1;
    end
    n_cmp++; if (seen_v !== 1'b0) begin n_fail++; $display("FAIL mid_late_beats got %b exp 0", seen_v); end
    do_read(32'h80, 16'd8);
    n_cmp++; if (rd_cnt !== 8) begin n_fail++; $display("FAIL mid_reread_cnt got %0d exp 8", rd_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rd_buf[i] !== 32'h60 + 32'(i)) begin n_fail++; $display("FAIL mid_reread%0d got %h exp %h", i, rd_buf[i], 32'h60 + 32'(i)); end
    end
    n_cmp++; if (rd_beats !== 32'd8) begin n_fail++; $display("FAIL mid_rd_beats got %0d exp 8", rd_beats); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap_write();
    test_bad_burstcount();
    test_rw_collision();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
